dual_port_ram: RTL and testbench
================================

# dual_port_ram

Parametrised successor to `single_ram`: a true dual-port synchronous RAM with two independent ports and per-byte write enables. Shared inout data bus replaced by separate write/read buses. Adds a hardware clear sequencer that zeroes the array after reset or on request. It is the general scratch/buffer memory for the datapath, and either port can serve a different master.

## Interface
- `ADDR_WIDTH`, 10, address bits; DEPTH = 2**ADDR_WIDTH words
- `DATA_WIDTH`, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `clear`  in  1  one-cycle pulse; restarts the zeroing sequence
- `ready`  out  1  high when the array accepts port requests
- Per port p in {a, b}:
  - `cs_p`  in  1  request valid this cycle
  - `we_p`  in  1  1 = write, 0 = read
  - `be_p`  in  NB  byte enables; used for writes only
  - `addr_p`  in  ADDR_WIDTH  word address
  - `wdata_p`  in  DATA_WIDTH  write data
  - `rdata_p`  out  DATA_WIDTH  read data; holds until the next accepted read on that port
  - `rvalid_p`  out  1  one-cycle pulse, rdata_p updated

## Operation
- FSM states: CLEAR, READY. Reset enters CLEAR with clear counter = 0.
- CLEAR: write 0 to word[counter] in all lanes each cycle, counter += 1. After the write to DEPTH-1, go to READY. `ready` = 0 throughout.
- READY: `ready` = 1. A `clear` pulse sets the counter to 0 and goes to CLEAR. Port requests in the same cycle as `clear` are still performed, because clearing starts on the next cycle.
- `clear` asserted while in CLEAR restarts the counter at 0.
- Port requests (`cs_p`=1) with `ready`=0 are ignored: no write, no rvalid.
- Write: for each lane i with be_p[i]=1, word[addr_p] byte i ← wdata_p byte i. If `be_p` is all zero, the request is accepted and has no effect.
- Read: rdata_p ← word[addr_p], rvalid_p ← 1 at the same edge. Otherwise rvalid_p ← 0.
- Collisions, same address in the same cycle:
  - Both ports write: each byte lane takes port A where be_a[i]=1, else port B where be_b[i]=1.
  - One port reads while the other writes: read-first; the reader gets the old word.
  - Both ports read: both return the same word.
- Array contents are not reset; only the clear sequence defines them.

## Timing
- Reset values: `ready` 0, `rdata_a`/`rdata_b` 0, `rvalid_a`/`rvalid_b` 0, FSM CLEAR, counter 0.
- Read latency: 1 cycle. The request is sampled at edge N, and rdata/rvalid are visible after edge N.
- Write-to-read: a write sampled at edge N is visible to any read sampled at edge N+1 or later.
- Clear duration: DEPTH cycles. `ready` rises at the edge after the write to DEPTH-1, which is DEPTH edges after `rst_n` deasserts or after the `clear` sample edge.
- `ready` falls at the edge after the `clear` sample edge.
- Reset asserted mid-operation: all outputs go to their reset values immediately. A clear sequence in progress is abandoned and restarts from 0 after release.
- Full throughput: both ports can issue one request per cycle, back-to-back, with no stalls while READY.

## Structure
- Package `dual_port_ram_pkg`: state enum `ram_state_t` {ST_CLEAR, ST_READY}, and a function returning NB from DATA_WIDTH.
- Sub-module `ram_byte_lane`: one 8-bit × DEPTH array with two write ports and two read ports, read-first. The top instantiates NB lanes and resolves port-A priority per lane. The top also holds the FSM, the clear counter and the read-output registers.

## Test plan
Bench parameters: ADDR_WIDTH=4, DATA_WIDTH=32.
- Release reset → `ready` = 0 for 16 cycles, then 1. Reads of addresses 0..15 return 0x00000000, each with a single-cycle `rvalid`.
- Port A writes addr 3 = 0xDEADBEEF with be=4'b1111, then writes addr 3 = 0x000000AA with be=4'b0001. Port B reads addr 3 → 0xDEADBEAA one cycle after its request.
- Same cycle, addr 5: A writes 0x11111111 with be=4'b0011, B writes 0x22222222 with be=4'b1111. A subsequent read → 0x22221111.
- Addr 7 holds 0x12345678. A writes 0xCAFEF00D while B reads addr 7 in the same cycle → B gets 0x12345678; a read on the next cycle gets 0xCAFEF00D.
- Pulse `clear` after filling the array with nonzero data → `ready` falls next cycle and any `cs` is ignored (no rvalid) for 16 cycles. Afterwards all reads return 0.
- Assert `rst_n` low mid-clear (counter = 8) → outputs zero immediately. After release, `ready` returns exactly 16 cycles later.

Source files
------------

// File: rtl/dual_port_ram_pkg.sv
// Shared types and helpers for the dual-port RAM and its port interface.
package dual_port_ram_pkg;

    // Sequencer states: zeroing the array, or serving port requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    // Number of byte lanes in a word of the given width.
    function automatic int num_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dual_port_ram_if.sv
// One RAM port: request fields from the master, read results back to it.
interface dual_port_ram_if
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) ();
    localparam int NB = num_lanes(DATA_WIDTH);

    logic                  cs;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output cs, we, be, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  cs, we, be, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/dual_port_ram_byte_lane.sv
// One 8-bit wide memory lane with two write ports and two asynchronous read
// ports. Reads return the contents before the current edge (read-first).
// Port A is written last, so it wins if both ports hit the same word, though
// the top already masks port B in that case.
module ram_byte_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] waddr_a,
    input  logic [7:0]            wdata_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] waddr_b,
    input  logic [7:0]            wdata_b,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [7:0]            rdata_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [7:0]            rdata_b
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] mem [DEPTH];

    // Byte writes from both ports; contents are never reset.
    always_ff @(posedge clk) begin
        if (we_b) mem[waddr_b] <= wdata_b;
        if (we_a) mem[waddr_a] <= wdata_a;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with per-byte enables and a clear sequencer that zeroes
// every word after reset or on a clear pulse. Requests are ignored while
// clearing; port A wins byte lanes on same-address write collisions.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    output logic           ready,
    dual_port_ram_if.slave port_a,
    dual_port_ram_if.slave port_b
);
    localparam int NB = num_lanes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    ram_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] count_reg, count_next;
    logic                  clearing;

    logic [DATA_WIDTH-1:0] rdata_a_reg, rdata_b_reg;
    logic                  rvalid_a_reg, rvalid_b_reg;

    logic                  wr_a, wr_b, rd_a, rd_b, same_addr;
    logic [NB-1:0]         wen_a, wen_b;
    logic [ADDR_WIDTH-1:0] lane_waddr_a;
    logic [DATA_WIDTH-1:0] word_a, word_b;

    // Sequencer state and clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_CLEAR;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next state: walk the counter over every word, then serve requests
    // until a clear pulse restarts the walk from word 0.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ready      = 1'b0;
        clearing   = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clearing = 1'b1;
                if (clear) begin
                    count_next = '0;
                end else if (count_reg == LAST_ADDR) begin
                    state_next = ST_READY;
                    count_next = '0;
                end else begin
                    count_next = count_reg + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                ready = 1'b1;
                if (clear) begin
                    state_next = ST_CLEAR;
                    count_next = '0;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    assign wr_a      = port_a.cs & ready & port_a.we;
    assign wr_b      = port_b.cs & ready & port_b.we;
    assign rd_a      = port_a.cs & ready & ~port_a.we;
    assign rd_b      = port_b.cs & ready & ~port_b.we;
    assign same_addr = (port_a.addr == port_b.addr);

    // While clearing, lane port A is borrowed to write zeros at the counter.
    assign lane_waddr_a = clearing ? count_reg : port_a.addr;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign wen_a[gi] = clearing | (wr_a & port_a.be[gi]);
            assign wen_b[gi] = wr_b & port_b.be[gi]
                             & ~(wr_a & port_a.be[gi] & same_addr);

            ram_byte_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
                .clk     (clk),
                .we_a    (wen_a[gi]),
                .waddr_a (lane_waddr_a),
                .wdata_a (clearing ? 8'h00 : port_a.wdata[8*gi +: 8]),
                .we_b    (wen_b[gi]),
                .waddr_b (port_b.addr),
                .wdata_b (port_b.wdata[8*gi +: 8]),
                .raddr_a (port_a.addr),
                .rdata_a (word_a[8*gi +: 8]),
                .raddr_b (port_b.addr),
                .rdata_b (word_b[8*gi +: 8])
            );
        end
    endgenerate

    // Read outputs: capture on an accepted read, otherwise hold the data and
    // drop the valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_reg  <= '0;
            rdata_b_reg  <= '0;
            rvalid_a_reg <= 1'b0;
            rvalid_b_reg <= 1'b0;
        end else begin
            rvalid_a_reg <= rd_a;
            rvalid_b_reg <= rd_b;
            if (rd_a) rdata_a_reg <= word_a;
            if (rd_b) rdata_b_reg <= word_b;
        end
    end

    assign port_a.rdata  = rdata_a_reg;
    assign port_a.rvalid = rvalid_a_reg;
    assign port_b.rdata  = rdata_b_reg;
    assign port_b.rvalid = rvalid_b_reg;
endmodule

// File: tb/tb_dual_port_ram.sv
// Randomised and directed bench for dual_port_ram against a word-level model.
module tb_dual_port_ram;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic ready;

    dual_port_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
    dual_port_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

    dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .ready  (ready),
        .port_a (if_a.slave),
        .port_b (if_b.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word array, busy-cycle countdown, expected outputs.
    logic [31:0] m_mem [DEPTH];
    logic        m_ready;
    int          m_left;
    logic [31:0] m_rdata_a, m_rdata_b;
    logic        m_rvalid_a, m_rvalid_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ready    = 1'b0;
        m_left     = DEPTH;
        m_rdata_a  = '0;
        m_rdata_b  = '0;
        m_rvalid_a = 1'b0;
        m_rvalid_b = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ready"},    {31'd0, ready},       {31'd0, m_ready});
        check({tag, ".rvalid_a"}, {31'd0, if_a.rvalid}, {31'd0, m_rvalid_a});
        check({tag, ".rvalid_b"}, {31'd0, if_b.rvalid}, {31'd0, m_rvalid_b});
        check({tag, ".rdata_a"},  if_a.rdata,           m_rdata_a);
        check({tag, ".rdata_b"},  if_b.rdata,           m_rdata_b);
    endtask

    task automatic set_idle();
        clear = 1'b0;
        if_a.cs = 1'b0; if_a.we = 1'b0; if_a.be = '0; if_a.addr = '0; if_a.wdata = '0;
        if_b.cs = 1'b0; if_b.we = 1'b0; if_b.be = '0; if_b.addr = '0; if_b.wdata = '0;
    endtask

    // Advance the model over the current inputs, clock the DUT, compare.
    task automatic tick(input string tag);
        m_rvalid_a = 1'b0;
        m_rvalid_b = 1'b0;
        if (m_ready) begin
            if (if_a.cs && !if_a.we) begin m_rdata_a = m_mem[if_a.addr]; m_rvalid_a = 1'b1; end
            if (if_b.cs && !if_b.we) begin m_rdata_b = m_mem[if_b.addr]; m_rvalid_b = 1'b1; end
            if (if_b.cs && if_b.we) m_mem[if_b.addr] = merge(m_mem[if_b.addr], if_b.wdata, if_b.be);
            if (if_a.cs && if_a.we) m_mem[if_a.addr] = merge(m_mem[if_a.addr], if_a.wdata, if_a.be);
            if (clear) begin m_ready = 1'b0; m_left = DEPTH; end
        end else begin
            m_mem[DEPTH - m_left] = '0;
            if (clear) m_left = DEPTH;
            else m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end
        if (clear || if_a.cs || if_b.cs)
            $display("%0t %s clr=%b A:cs=%b we=%b be=%h ad=%0d wd=%h B:cs=%b we=%b be=%h ad=%0d wd=%h",
                     $time, tag, clear, if_a.cs, if_a.we, if_a.be, if_a.addr, if_a.wdata,
                     if_b.cs, if_b.we, if_b.be, if_b.addr, if_b.wdata);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic drive_a(input logic cs, input logic we, input logic [3:0] be,
                           input logic [3:0] addr, input logic [31:0] wdata);
        if_a.cs = cs; if_a.we = we; if_a.be = be; if_a.addr = addr; if_a.wdata = wdata;
    endtask

    task automatic drive_b(input logic cs, input logic we, input logic [3:0] be,
                           input logic [3:0] addr, input logic [31:0] wdata);
        if_b.cs = cs; if_b.we = we; if_b.be = be; if_b.addr = addr; if_b.wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hxxxx_xxxx;
        set_idle();
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Initial clear: ready low for 16 edges, then high.
        for (int i = 0; i < DEPTH; i++) tick("init_clear");
        check("ready_after_init", {31'd0, ready}, 32'd1);

        // Every word reads back zero on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            drive_a(1'b1, 1'b0, 4'h0, 4'(i), '0);
            drive_b(1'b1, 1'b0, 4'h0, 4'(DEPTH - 1 - i), '0);
            tick("zero_read");
            check("zero_read_a", if_a.rdata, 32'h0);
        end
        set_idle();
        tick("idle");

        // Byte-enable merge.
        drive_a(1'b1, 1'b1, 4'b1111, 4'd3, 32'hDEADBEEF); tick("wr3_full");
        drive_a(1'b1, 1'b1, 4'b0001, 4'd3, 32'h000000AA); tick("wr3_byte");
        set_idle();
        drive_b(1'b1, 1'b0, 4'h0, 4'd3, '0); tick("rd3");
        check("be_merge", if_b.rdata, 32'hDEADBEAA);

        // Same-address write collision: A wins enabled lanes.
        set_idle();
        drive_a(1'b1, 1'b1, 4'b0011, 4'd5, 32'h11111111);
        drive_b(1'b1, 1'b1, 4'b1111, 4'd5, 32'h22222222);
        tick("wr5_collide");
        set_idle();
        drive_a(1'b1, 1'b0, 4'h0, 4'd5, '0); tick("rd5");
        check("collide_merge", if_a.rdata, 32'h22221111);

        // Read-first on a read/write collision.
        set_idle();
        drive_a(1'b1, 1'b1, 4'b1111, 4'd7, 32'h12345678); tick("wr7");
        drive_a(1'b1, 1'b1, 4'b1111, 4'd7, 32'hCAFEF00D);
        drive_b(1'b1, 1'b0, 4'h0, 4'd7, '0);
        tick("wr7_rd7");
        check("read_first_old", if_b.rdata, 32'h12345678);
        set_idle();
        drive_b(1'b1, 1'b0, 4'h0, 4'd7, '0); tick("rd7_new");
        check("read_first_new", if_b.rdata, 32'hCAFEF00D);

        // Random traffic with biased address collisions and rare clears.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] aa, ab;
            aa = 4'($urandom_range(0, DEPTH - 1));
            ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, DEPTH - 1));
            drive_a(1'($urandom), 1'($urandom), 4'($urandom), aa, $urandom);
            drive_b(1'($urandom), 1'($urandom), 4'($urandom), ab, $urandom);
            clear = ($urandom_range(0, 63) == 0);
            tick("rand");
        end
        set_idle();
        while (!m_ready) tick("rand_drain");

        // Fill with nonzero data, then clear with requests still arriving.
        for (int i = 0; i < DEPTH; i++) begin
            drive_a(1'b1, 1'b1, 4'b1111, 4'(i), 32'h8000_0000 | $urandom);
            tick("fill");
        end
        set_idle();
        clear = 1'b1;
        drive_a(1'b1, 1'b0, 4'h0, 4'd2, '0);
        tick("clear_pulse");
        check("ready_fall", {31'd0, ready}, 32'd0);
        clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_a(1'b1, 1'($urandom), 4'hF, 4'($urandom), $urandom);
            drive_b(1'b1, 1'b0, 4'h0, 4'($urandom), '0);
            tick("busy_ignored");
            check("busy_no_rvalid_b", {31'd0, if_b.rvalid}, 32'd0);
        end
        set_idle();
        for (int i = 0; i < DEPTH; i++) begin
            drive_a(1'b1, 1'b0, 4'h0, 4'(i), '0);
            tick("post_clear_read");
            check("post_clear_zero", if_a.rdata, 32'h0);
        end

        // Reset in the middle of a clear sequence.
        set_idle();
        clear = 1'b1; tick("clear2");
        clear = 1'b0;
        for (int i = 0; i < 8; i++) tick("clear2_run");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("midclear_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick("reclear");
        check("ready_after_reclear", {31'd0, ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
